// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit multiplexed seven-segment scanner.
// Holds the glyph/anode idle patterns, the digit count and the leading-zero helper.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] value;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
        logic                       lz_en;
    } shadow_t;

    // Bit k set when nibbles k..top are all zero; digit 0 is never suppressible.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS-1:0][3:0] v);
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (v[k] == 4'h0);
            lz_mask[k] = upper_zero;
        end
    endfunction

endpackage

// File: rtl/bin_to_hex_7seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} glyph decoder.
// Purely combinational, zero latency, no backpressure.
module bin_to_hex_7seg
    import seg_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nib_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with per-slot anti-ghost blanking.
// Outputs registered, one cycle behind tick/idx; free-running, no backpressure.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           value,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic [NUM_DIGITS-1:0] blank,
    input  logic                  lz_en,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] DRIVE_MIN = TICK_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    shadow_t               shadow_q, shadow_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            nib;
    logic [SEG_W-1:0]      glyph;
    logic [NUM_DIGITS-1:0] lz_sup;
    logic                  dark;

    assign slot_end  = (tick_q == TICK_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign nib       = shadow_q.value[idx_q];
    assign lz_sup    = lz_mask(shadow_q.value);

    bin_to_hex_7seg u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        tick_d = slot_end ? '0 : tick_q + TICK_W'(1);
        idx_d  = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        shadow_d = shadow_q;
        if (frame_end) begin
            shadow_d.value = value;
            shadow_d.dp    = dp_in;
            shadow_d.blank = blank;
            shadow_d.lz_en = lz_en;
        end
    end

    // The blank phase at the head of every slot also guarantees no two anodes
    // overlap across a digit change.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        dark  = shadow_q.blank[idx_q] | (shadow_q.lz_en & lz_sup[idx_q]);
        if (tick_q >= DRIVE_MIN) begin
            an_d[idx_q] = 1'b0;
            if (!dark) begin
                seg_d = glyph;
            end
            if (!shadow_q.blank[idx_q]) begin
                dp_d = ~shadow_q.dp[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q        <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_end;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with an 8-cycle slot and 2 blank cycles.
module tb_seg_scan_driver;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp_in       (dp_in),
        .blank       (blank),
        .lz_en       (lz_en),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_push, e_pop;

    int          m_tick = 0;
    int          m_idx  = 0;
    logic [15:0] m_val  = 16'h0;
    logic [3:0]  m_dp   = 4'h0;
    logic [3:0]  m_blk  = 4'h0;
    logic        m_lz   = 1'b0;
    logic [3:0]  one_hot = 4'b0001;
    logic [3:0]  m_nib;
    logic        m_sup;

    // Reference model: expected registered outputs for the cycle after this edge.
    always @(posedge clk) begin
        if (rst) begin
            e_push = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
            m_tick = 0;
            m_idx  = 0;
            m_val  = 16'h0;
            m_dp   = 4'h0;
            m_blk  = 4'h0;
            m_lz   = 1'b0;
        end else begin
            e_push = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: (m_tick == DIV - 1 && m_idx == 3)};
            if (m_tick >= BLK) begin
                e_push.an = ~(one_hot << m_idx);
                m_nib = m_val[m_idx*4 +: 4];
                m_sup = m_lz && (m_idx > 0) && ((m_val >> (m_idx * 4)) == 16'h0);
                if (!m_blk[m_idx] && !m_sup) e_push.seg = glyph_tbl[m_nib];
                if (!m_blk[m_idx]) e_push.dp = ~m_dp[m_idx];
            end
            if (m_tick == DIV - 1) begin
                m_tick = 0;
                if (m_idx == 3) begin
                    m_idx = 0;
                    m_val = value;
                    m_dp  = dp_in;
                    m_blk = blank;
                    m_lz  = lz_en;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_tick = m_tick + 1;
            end
        end
        sb_q.push_back(e_push);
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e_pop = sb_q.pop_front();
            chk("seg", seg, e_pop.seg);
            chk("dp", dp, e_pop.dp);
            chk("an", an, e_pop.an);
            chk("frame_start", frame_start, e_pop.fs);
            chk("an_onehot", ($countones(~an) <= 1), 1'b1);
        end
    end

    int         low_cnt [4];
    logic [6:0] last_seg [4];
    int         fs_cnt;

    // Observe one 32-cycle frame window; optionally change value at cycle chg_at.
    task automatic frame_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input int chg_at, input logic [15:0] chg_val);
        logic [6:0] exp_g [4];
        exp_g[0] = e0; exp_g[1] = e1; exp_g[2] = e2; exp_g[3] = e3;
        fs_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            low_cnt[k]  = 0;
            last_seg[k] = 7'h55;
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
            for (int k = 0; k < 4; k++) begin
                if (!an[k]) begin
                    low_cnt[k]++;
                    last_seg[k] = seg;
                end
            end
            if (i == chg_at) value = chg_val;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_low%0d", tag, k), low_cnt[k], 6);
            chk($sformatf("%s_glyph%0d", tag, k), last_seg[k], exp_g[k]);
        end
        chk({tag, "_fs"}, fs_cnt, 1);
    endtask

    initial begin
        value = 16'h12AF;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        rst = 1'b0;

        frame_check("f1_zero", 7'h40, 7'h40, 7'h40, 7'h40, -1, 16'h0);
        value = 16'h0050; lz_en = 1'b1; dp_in = 4'b0100;
        frame_check("f2_12af", 7'h0E, 7'h08, 7'h24, 7'h79, -1, 16'h0);
        value = 16'h0000; dp_in = 4'b0000;
        frame_check("f3_0050", 7'h40, 7'h12, 7'h7F, 7'h7F, -1, 16'h0);
        value = 16'h1111; lz_en = 1'b0; blank = 4'b0010;
        frame_check("f4_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0);
        frame_check("f5_1111", 7'h79, 7'h7F, 7'h79, 7'h79, 9, 16'h2222);
        blank = 4'b0000;
        frame_check("f6_2222", 7'h24, 7'h7F, 7'h24, 7'h24, -1, 16'h0);

        repeat (20) @(negedge clk);
        chk("pre_rst_an", an, 4'b1011);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 7'h7F);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_blank0", an, 4'hF);
        @(negedge clk);
        chk("post_rst_blank1", an, 4'hF);
        @(negedge clk);
        chk("post_rst_digit0", an, 4'b1110);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            blank = 4'($urandom);
            lz_en = 1'($urandom);
            rst   = ($urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 1000, SHALL set the anti-ghost blank cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 clk  input  1  system clock, all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 value  input  16  four hex nibbles; digit k shows value[4k+3:4k].
REQ-006 dp_in  input  4  active-high decimal point request per digit.
REQ-007 blank  input  4  active-high forced blank per digit.
REQ-008 lz_en  input  1  leading-zero suppression enable.
REQ-009 seg  output  7  active-low segment pattern {g,f,e,d,c,b,a}, registered.
REQ-010 dp  output  1  active-low decimal point, registered.
REQ-011 an  output  4  active-low anode select, one-hot-low or all-high, registered.
REQ-012 frame_start  output  1  one-cycle pulse when the digit index wraps 3->0.

Function
REQ-013 Slot counter tick SHALL count 0..REFRESH_DIV-1 and wrap to 0; the digit index idx SHALL advance 0->1->2->3->0 on the cycle tick wraps.
REQ-014 Shadow register SHALL capture value, dp_in, blank and lz_en in the same cycle idx wraps 3->0; inputs that change mid-frame SHALL NOT affect the frame in progress.
REQ-015 frame_start SHALL assert for exactly the cycle the shadow capture occurs.
REQ-016 While tick < BLANK_CYC, an SHALL be 4'b1111, seg 7'b1111111 and dp 1 (blank phase).
REQ-017 While tick >= BLANK_CYC, an[idx] SHALL be 0 and all other an bits 1 (drive phase).
REQ-018 Outputs SHALL be registered with one cycle of latency from tick/idx: the output on cycle n+1 reflects tick/idx of cycle n.
REQ-019 In drive phase, seg SHALL be the hex glyph (0-9, A, b, C, d, E, F) of the shadow nibble for idx; dp SHALL be the inverse of shadow dp_in[idx].
REQ-020 A digit SHALL be blanked (seg 7'b1111111, dp 1, anode still driven) if shadow blank[idx]=1.
REQ-021 With shadow lz_en=1, digit k (k=3,2,1) SHALL be blanked when nibbles k..3 are all zero; digit 0 SHALL never be zero-suppressed; dp_in still overrides suppression for dp only.
REQ-022 Value 16'h0000 with lz_en=1 SHALL display a single "0" on digit 0.
REQ-023 At most one an bit SHALL be low on any cycle, including the reset cycle and idx transitions.

Reset
REQ-024 While rst=1: tick=0, idx=0, shadow=all zero, an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
REQ-025 Reset asserted mid-slot SHALL take effect on the next clk edge; after release scanning SHALL restart at digit 0, tick 0, blank phase first.
REQ-026 The first shadow capture after reset SHALL occur at the first 3->0 wrap; until then the displayed shadow is zero.

Structure
REQ-027 Package seg_pkg SHALL hold the glyph constants (blank pattern, anode-off pattern) and the digit count (4).
REQ-028 Counter widths SHALL derive from $clog2(REFRESH_DIV); no hard-coded widths.
REQ-029 Nibble-to-glyph decode SHALL instantiate the existing bin_to_hex_7seg sub-module once, fed by the idx-selected shadow nibble; no second decoder copy.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-030 value=16'h12AF, lz_en=0, after reset -> first frame all "0"; second frame digit0 seg 7'b0001110 (F), digit1 7'b0001000 (A), digit2 7'b0100100 (2), digit3 7'b1111001 (1), each low for 6 of 8 cycles.
REQ-031 value=16'h0050, lz_en=1 -> digits 3,2 blank, digit1 "5" (7'b0010010), digit0 "0"; value=0 -> only digit0 "0".
REQ-032 value changed from 16'h1111 to 16'h2222 while idx=1 -> remainder of frame shows "1", next frame shows "2"; frame_start pulses once per 32 cycles.
REQ-033 rst pulsed for 1 cycle while idx=2, drive phase -> next cycle an=4'b1111, seg=7'b1111111; scanning resumes at digit 0 with 2 blank cycles.
REQ-034 Every cycle of a 1000-cycle random-input run -> an never has more than one 0 bit; blank[k]=1 gives seg=7'b1111111 on digit k.
